uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer handshake and status bundle for uart_rx.
// slave  = receiver side (drives received byte and flags)
// master = consumer side (drives the line and the read strobe)
interface uart_rx_if;
    logic       read;
    logic       rx;
    logic [7:0] dataout;
    logic       rxrdy;
    logic       parityerr;
    logic       framingerr;
    logic       overrun;

    modport slave (
        input  read,
        input  rx,
        output dataout,
        output rxrdy,
        output parityerr,
        output framingerr,
        output overrun
    );

    modport master (
        output read,
        output rx,
        input  dataout,
        input  rxrdy,
        input  parityerr,
        input  framingerr,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, 8 data bits LSB first, 1 stop bit.
// Optional odd parity bit enabled by defining UART_RX_PARITY_EN; without it
// the parity state is skipped and parityerr stays 0.
// Status outputs update one cycle after the stop-bit sample.
module uart_rx (
    input  logic     mclkx16,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic       sync1_r;
    logic       rxs_r;
    logic       rxs_prev_r;
    logic [2:0] state_r,    state_s;
    logic [3:0] cnt_r,      cnt_s;
    logic [3:0] tick_s;
    logic [2:0] bitcnt_r,   bitcnt_s;
    logic [7:0] shift_r,    shift_s;
    logic       stop_bit_r, stop_bit_s;
    logic       done_r,     done_s;
    logic       ovr_pend_r, ovr_pend_s;
    logic       parity_err_s;
    logic [7:0] dataout_r;
    logic       rxrdy_r;
    logic       parityerr_r;
    logic       framingerr_r;
    logic       overrun_r;

`ifdef UART_RX_PARITY_EN
    logic       par_bit_r,  par_bit_s;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_err(input logic [7:0] d, input logic p);
        return ((^d) ^ p) != 1'b1;
    endfunction

    assign parity_err_s = odd_parity_err(shift_r, par_bit_r);
`else
    assign parity_err_s = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous line plus one history flop for edge detect.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync1_r    <= bus.rx;
            rxs_r      <= sync1_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Frame FSM next-state: start qualified after 7 ticks, later bits every 16 ticks.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        tick_s     = cnt_r + 4'd1;
        bitcnt_s   = bitcnt_r;
        shift_s    = shift_r;
        stop_bit_s = stop_bit_r;
        done_s     = 1'b0;
        ovr_pend_s = ovr_pend_r;
`ifdef UART_RX_PARITY_EN
        par_bit_s  = par_bit_r;
`endif
        case (state_r)
            S_IDLE: begin
                cnt_s    = 4'd0;
                bitcnt_s = 3'd0;
                if (rxs_prev_r && !rxs_r) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s == 4'd7) begin
                    cnt_s = 4'd0;
                    // A high line at mid start bit is a glitch, not a frame.
                    if (!rxs_r) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = tick_s;
                end
            end
            S_DATA: begin
                if (cnt_r == 4'd15) begin
                    cnt_s    = 4'd0;
                    shift_s  = {rxs_r, shift_r[7:1]};
                    bitcnt_s = bitcnt_r + 3'd1;
                    if (bitcnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    cnt_s = tick_s;
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_r == 4'd15) begin
                    cnt_s     = 4'd0;
                    par_bit_s = rxs_r;
                    state_s   = S_STOP;
                end else begin
                    cnt_s = tick_s;
                end
`else
                // Unreachable without parity; recover to idle.
                cnt_s   = 4'd0;
                state_s = S_IDLE;
`endif
            end
            S_STOP: begin
                if (cnt_r == 4'd15) begin
                    cnt_s      = 4'd0;
                    stop_bit_s = rxs_r;
                    done_s     = 1'b1;
                    // A read in this same cycle frees the old byte, so no overrun.
                    ovr_pend_s = rxrdy_r & ~bus.read;
                    state_s    = S_IDLE;
                end else begin
                    cnt_s = tick_s;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = S_IDLE;
            end
        endcase
    end

    // Frame FSM state, counters and shift register.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 4'd0;
            bitcnt_r   <= 3'd0;
            shift_r    <= 8'h00;
            stop_bit_r <= 1'b0;
            done_r     <= 1'b0;
            ovr_pend_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bitcnt_r   <= bitcnt_s;
            shift_r    <= shift_s;
            stop_bit_r <= stop_bit_s;
            done_r     <= done_s;
            ovr_pend_r <= ovr_pend_s;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= par_bit_s;
`endif
        end
    end

    // Status/data outputs: frame completion has priority over a coincident read.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            dataout_r    <= 8'h00;
            rxrdy_r      <= 1'b0;
            parityerr_r  <= 1'b0;
            framingerr_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (done_r) begin
            dataout_r    <= shift_r;
            rxrdy_r      <= 1'b1;
            parityerr_r  <= parity_err_s;
            framingerr_r <= ~stop_bit_r;
            overrun_r    <= ovr_pend_r;
        end else if (bus.read) begin
            rxrdy_r      <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            rxrdy_r      <= rxrdy_r;
            overrun_r    <= overrun_r;
        end
    end

    assign bus.dataout    = dataout_r;
    assign bus.rxrdy      = rxrdy_r;
    assign bus.parityerr  = parityerr_r;
    assign bus.framingerr = framingerr_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level reference model.
// Timing reference: rx driven low right after edge T; two synchronizer edges
// later the first cycle with rxs=0 ends at edge T+3, so the completion update
// lands on edge T+3+152 (T+3+168 with parity), i.e. after drive step k=154 (170).
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS  = PAR_EN ? 11 : 10;
    localparam int DONE_K = PAR_EN ? 170 : 154;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_if bus ();

    uart_rx dut (
        .mclkx16 (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference model state (what the outputs should show)
    logic [7:0] m_data;
    logic       m_rdy, m_pe, m_fe, m_ov;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, bus.dataout, m_data);
        chk({tag, ".rxrdy"}, 8'(bus.rxrdy), 8'(m_rdy));
        chk({tag, ".perr"}, 8'(bus.parityerr), 8'(m_pe));
        chk({tag, ".ferr"}, 8'(bus.framingerr), 8'(m_fe));
        chk({tag, ".ovr"}, 8'(bus.overrun), 8'(m_ov));
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_pe   = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse();
        bus.read = 1'b1;
        @(posedge clk);
        #1;
        bus.read = 1'b0;
        m_rdy = 1'b0;
        m_ov  = 1'b0;
    endtask

    // rx low for only 5 cycles: must not produce a frame
    task automatic glitch();
        bus.rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(30);
    endtask

    // Drive one frame, one step per clock. rd_k / rst_k select a step at which
    // read (one cycle) or reset (two cycles) is asserted; -1 means none.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int rd_k, input int rst_k, input string tag);
        logic [10:0] bits;
        logic        aborted;
        logic        ov_pend;
        aborted = 1'b0;
        ov_pend = 1'b0;
        bits = PAR_EN ? {stop, p, d, 1'b0} : {1'b0, stop, d, 1'b0};
        for (int k = 0; k < NBITS * 16; k++) begin
            bus.rx   = bits[k / 16];
            bus.read = (k == rd_k);
            reset    = (rst_k >= 0) && (k == rst_k || k == rst_k + 1);
            @(posedge clk);
            #1;
            if (reset) begin
                model_reset();
                aborted = 1'b1;
            end else begin
                if (!aborted && k == DONE_K - 1) begin
                    ov_pend = m_rdy && !bus.read;
                end
                if (!aborted && k == DONE_K) begin
                    m_data = d;
                    m_rdy  = 1'b1;
                    m_fe   = ~stop;
                    m_pe   = PAR_EN ? (((^d) ^ p) != 1'b1) : 1'b0;
                    m_ov   = ov_pend;
                end else if (bus.read) begin
                    m_rdy = 1'b0;
                    m_ov  = 1'b0;
                end
            end
            if (!aborted && (k == DONE_K - 1 || k == DONE_K)) begin
                check_all($sformatf("%s.k%0d", tag, k));
            end
            if (rst_k >= 0 && k == rst_k + 1) begin
                check_all({tag, ".rst"});
            end
        end
        bus.read = 1'b0;
        reset    = 1'b0;
        idle(4);
    endtask

    initial begin
        logic [7:0] d;
        logic       p, stop;
        int         rd_k;
        bus.rx   = 1'b1;
        bus.read = 1'b0;
        reset    = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        idle(8);

        send_frame(8'hA5, 1'b1, 1'b1, -1, -1, "a5");
        rd_pulse();
        check_all("a5.read");

        glitch();
        check_all("glitch");

        send_frame(8'h3C, 1'b1, 1'b0, -1, -1, "3c_badstop");
        rd_pulse();
        send_frame(8'h01, 1'b0, 1'b1, -1, -1, "01");
        rd_pulse();

        send_frame(8'h11, 1'b1, 1'b1, -1, -1, "11");
        send_frame(8'h22, 1'b1, 1'b1, -1, -1, "22_ovr");
        rd_pulse();
        check_all("ovr.read");

        send_frame(8'h07, 1'b0, 1'b1, -1, -1, "07_p0");
        rd_pulse();
        send_frame(8'h07, 1'b1, 1'b1, -1, -1, "07_p1");
        rd_pulse();

        // read on the completion edge: new byte still counts as unread
        send_frame(8'h33, 1'b1, 1'b1, DONE_K, -1, "coinc");
        check_all("coinc.after");
        // read on the stop-sample edge with an unread byte: no overrun
        send_frame(8'h44, 1'b0, 1'b1, DONE_K - 1, -1, "rdstop");
        check_all("rdstop.after");

        // reset in the middle of data bit 4
        send_frame(8'hFF, 1'b1, 1'b1, -1, 88, "ff_rst");
        check_all("ff_rst.after");
        send_frame(8'h5A, 1'b1, 1'b1, -1, -1, "5a");
        rd_pulse();

        for (int i = 0; i < 20; i++) begin
            d    = 8'($urandom_range(0, 255));
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rd_k = DONE_K - 1;
                1:       rd_k = DONE_K;
                2:       rd_k = $urandom_range(20, 140);
                default: rd_k = -1;
            endcase
            send_frame(d, p, stop, rd_k, -1, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                rd_pulse();
                check_all($sformatf("rnd%0d.read", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
